apb_master: RTL and testbench

- APB initiator (bridge) that converts a simple single-transfer command interface into APB SETUP/ACCESS sequences.
- Decodes the upper address field to one of NUM_SLV PSEL lines and muxes the selected responder's PRDATA/PREADY back.
- Sits between the system-bus command source (CPU/testbench driver) and the APB peripheral slaves (register banks, GPIO, etc.).

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master_if.sv | 37 +++
 rtl/apb_addr_decoder.sv | 41 ++++
 rtl/apb_master.sv | 127 ++++++++++++
 tb/tb_apb_master.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared state type and default bus widths for the APB master slice.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Command-side and APB-side signals of the APB master, bundled with master/slave views.
interface apb_master_if import apb_pkg::*; #(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int NUM_SLV = 4
) ();

  logic                      i_transfer;
  logic                      i_write;
  logic [ADDR_W-1:0]         i_addr;
  logic [DATA_W-1:0]         i_wdata;
  logic                      o_ready;
  logic                      o_done;
  logic                      o_error;
  logic [DATA_W-1:0]         o_rdata;

  logic [ADDR_W-1:0]         PADDR;
  logic                      PWRITE;
  logic [DATA_W-1:0]         PWDATA;
  logic                      PENABLE;
  logic [NUM_SLV-1:0]        PSEL;
  logic [NUM_SLV*DATA_W-1:0] PRDATA_S;
  logic [NUM_SLV-1:0]        PREADY_S;

  modport master (
    input  i_transfer, i_write, i_addr, i_wdata, PRDATA_S, PREADY_S,
    output o_ready, o_done, o_error, o_rdata,
           PADDR, PWRITE, PWDATA, PENABLE, PSEL
  );

  modport slave (
    output i_transfer, i_write, i_addr, i_wdata, PRDATA_S, PREADY_S,
    input  o_ready, o_done, o_error, o_rdata,
           PADDR, PWRITE, PWDATA, PENABLE, PSEL
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Decodes the address field above SLV_SEL_LSB into a one-hot PSEL and muxes the
// selected responder's PRDATA/PREADY; any field value >= NUM_SLV is unmapped.
module apb_addr_decoder import apb_pkg::*; #(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int NUM_SLV     = 4,
  parameter int SLV_SEL_LSB = 12
) (
  input  logic [ADDR_W-SLV_SEL_LSB-1:0] addr_hi,
  input  logic                          sel_en,
  input  logic [NUM_SLV*DATA_W-1:0]     prdata_s,
  input  logic [NUM_SLV-1:0]            pready_s,
  output logic [NUM_SLV-1:0]            psel,
  output logic                          dec_err,
  output logic [DATA_W-1:0]             prdata,
  output logic                          pready
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int UP_W  = ADDR_W - SLV_SEL_LSB;

  logic [SEL_W-1:0] idx;

  assign idx     = addr_hi[SEL_W-1:0];
  // Bits above the index field must be zero too, so aliases are not mapped.
  assign dec_err = (addr_hi >= UP_W'(NUM_SLV));

  always_comb begin
    psel   = '0;
    prdata = '0;
    pready = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == SEL_W'(i)) begin
        psel[i] = sel_en && !dec_err;
        prdata  = prdata_s[i*DATA_W +: DATA_W];
        pready  = pready_s[i];
      end
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB initiator: turns single-transfer commands into SETUP/ACCESS sequences.
// Optional ACCESS wait timeout is built when APB_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | o_ready=1, command registered onto PADDR/PWDATA/PWRITE on accept
// SETUP  | PSEL asserted, PENABLE low, one cycle
// ACCESS | PSEL+PENABLE, wait for the selected PREADY (or timeout)
// DONE   | one-cycle o_done/o_error pulse, bus released
module apb_master import apb_pkg::*; #(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int NUM_SLV     = 4,
  parameter int SLV_SEL_LSB = 12,
  parameter int TIMEOUT     = 255
) (
  input  logic         PCLK,
  input  logic         PRESET,
  apb_master_if.master bus
);

  apb_state_e state, state_nxt;

  logic [ADDR_W-1:0]             paddr_q;
  logic [DATA_W-1:0]             pwdata_q;
  logic [DATA_W-1:0]             rdata_q;
  logic [DATA_W-1:0]             prdata;
  logic [ADDR_W-SLV_SEL_LSB-1:0] dec_hi;
  logic                          pwrite_q;
  logic                          err_q;
  logic                          dec_err;
  logic                          pready;
  logic                          sel_en;
  logic                          accept;
  logic                          timeout_hit;

  assign accept = (state == IDLE) && bus.i_transfer;
  assign sel_en = (state == SETUP) || (state == ACCESS);
  // In IDLE the incoming command is decoded so an unmapped one can skip SETUP.
  assign dec_hi = (state == IDLE) ? bus.i_addr[ADDR_W-1:SLV_SEL_LSB]
                                  : paddr_q[ADDR_W-1:SLV_SEL_LSB];

  apb_addr_decoder #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .NUM_SLV     (NUM_SLV),
    .SLV_SEL_LSB (SLV_SEL_LSB)
  ) u_dec (
    .addr_hi  (dec_hi),
    .sel_en   (sel_en),
    .prdata_s (bus.PRDATA_S),
    .pready_s (bus.PREADY_S),
    .psel     (bus.PSEL),
    .dec_err  (dec_err),
    .prdata   (prdata),
    .pready   (pready)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !pready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = !pready && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_transfer) state_nxt = dec_err ? DONE : SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        paddr_q  <= bus.i_addr;
        pwdata_q <= bus.i_wdata;
        pwrite_q <= bus.i_write;
        err_q    <= dec_err;
      end
      if (state == ACCESS) begin
        if (pready) begin
          if (!pwrite_q) rdata_q <= prdata;
        end else if (timeout_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.o_ready = (state == IDLE);
  assign bus.o_done  = (state == DONE);
  assign bus.o_error = (state == DONE) && err_q;
  assign bus.o_rdata = rdata_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PENABLE = (state == ACCESS);

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: responders with programmable wait states and
// a transaction-level model of latency, select pattern, error and read data.
module tb_apb_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int LSB = 12;
  localparam int TMO = 8;
`ifdef APB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus ();

  apb_master #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .SLV_SEL_LSB(LSB), .TIMEOUT(TMO)
  ) u_dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus.master)
  );

  int          checks   = 0;
  int          failures = 0;
  int          wait_cfg = 0;
  int          acc_cyc  = 0;
  logic [31:0] rd_cfg   = '0;
  logic [31:0] exp_rdata;
  logic [3:0]  rdy_noise;
  logic [31:0] data_noise;

  // Responder side: selected slave becomes ready after wait_cfg ACCESS cycles,
  // everything else (including SETUP) carries random ready/data noise.
  always @(posedge PCLK) begin
    rdy_noise  <= 4'($urandom);
    data_noise <= $urandom;
    if (bus.PENABLE) acc_cyc <= acc_cyc + 1;
    else             acc_cyc <= 0;
  end

  always_comb begin
    bus.PREADY_S = rdy_noise;
    bus.PRDATA_S = {NS{data_noise}};
    for (int i = 0; i < NS; i++) begin
      if (bus.PSEL[i] && bus.PENABLE) begin
        bus.PREADY_S[i] = (acc_cyc >= wait_cfg);
        if (acc_cyc >= wait_cfg) bus.PRDATA_S[i*DW +: DW] = rd_cfg;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command at the current negedge and follow it to o_done.
  // hold keeps i_transfer asserted; chained means issued during the previous DONE.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, input int waits, input bit hold, input bit chained);
    int          up, n, psel_n, pen_n, bad_sel, bad_bus, exp_pen, exp_lat;
    bit          err, tmo, done, err_seen;
    logic [31:0] rdata_seen;
    up = int'(addr >> LSB);
    err = (up >= NS);
    tmo = !err && TMO_EN && (waits >= TMO);
    n = 0; psel_n = 0; pen_n = 0; bad_sel = 0; bad_bus = 0;
    done = 0; err_seen = 0; rdata_seen = '0;
    if (!chained) check("ready_before", bus.o_ready, 1);
    bus.i_transfer = 1'b1;
    bus.i_write    = wr;
    bus.i_addr     = addr;
    bus.i_wdata    = wd;
    rd_cfg         = rd;
    wait_cfg       = waits;
    while (!done && n < 64) begin
      @(negedge PCLK);
      n++;
      if (!hold) bus.i_transfer = 1'b0;
      if (bus.PSEL != '0) begin
        psel_n++;
        if (bus.PSEL !== 4'(1 << (up & 3))) bad_sel++;
        if (bus.PADDR !== addr || bus.PWDATA !== wd || bus.PWRITE !== wr) bad_bus++;
      end
      if (bus.PENABLE) pen_n++;
      if (bus.o_done) begin
        done       = 1;
        err_seen   = bus.o_error;
        rdata_seen = bus.o_rdata;
      end
    end
    exp_pen = err ? 0 : (tmo ? TMO : waits + 1);
    exp_lat = (chained ? 1 : 0) + (err ? 1 : exp_pen + 2);
    check("done_seen", done, 1);
    check("latency", n, exp_lat);
    check("psel_cycles", psel_n, err ? 0 : exp_pen + 1);
    check("penable_cycles", pen_n, exp_pen);
    check("psel_onehot", bad_sel, 0);
    check("bus_stable", bad_bus, 0);
    check("error", err_seen, err || tmo);
    if (!wr && !err && !tmo) exp_rdata = rd;
    check("rdata", rdata_seen, exp_rdata);
    if (!hold) begin
      @(negedge PCLK);
      check("done_pulse", bus.o_done, 0);
      check("ready_after", bus.o_ready, 1);
      check("paddr_hold", bus.PADDR, addr);
    end
  endtask

  initial begin
    logic [31:0] up_r, addr_r;
    int          nd;
    PRESET         = 1'b1;
    bus.i_transfer = 1'b0;
    bus.i_write    = 1'b0;
    bus.i_addr     = '0;
    bus.i_wdata    = '0;
    exp_rdata      = '0;
    repeat (2) @(negedge PCLK);
    check("rst_ready",   bus.o_ready, 1);
    check("rst_done",    bus.o_done, 0);
    check("rst_error",   bus.o_error, 0);
    check("rst_rdata",   bus.o_rdata, 0);
    check("rst_paddr",   bus.PADDR, 0);
    check("rst_pwdata",  bus.PWDATA, 0);
    check("rst_pwrite",  bus.PWRITE, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_psel",    bus.PSEL, 0);
    PRESET = 1'b0;
    @(negedge PCLK);

    xfer(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    xfer(1'b0, 32'h0000_2008, 32'h0, 32'h1234_5678, 1, 0, 0);
    xfer(1'b0, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 0, 0, 0);

    // i_transfer held high, alternating write/read to slave 0
    for (int k = 0; k < 6; k++)
      xfer((k % 2) == 0, 32'h0000_0010 + 32'(4 * k), $urandom, $urandom, 0, 1, k > 0);
    bus.i_transfer = 1'b0;
    @(negedge PCLK);

    for (int k = 0; k < 40; k++) begin
      up_r   = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(4, 1 << 19))
                                            : 32'($urandom_range(0, 3));
      addr_r = (up_r << LSB) | ($urandom & 32'h0000_0FFC);
      xfer(1'($urandom_range(0, 1)), addr_r, $urandom, $urandom, $urandom_range(0, 3), 0, 0);
    end

`ifdef APB_TIMEOUT_EN
    xfer(1'b0, 32'h0000_3000, 32'h0, 32'h55AA_55AA, 1000, 0, 0);
`endif

    // read to a responder that never answers, then reset in ACCESS
    bus.i_transfer = 1'b1;
    bus.i_write    = 1'b0;
    bus.i_addr     = 32'h0000_3010;
    rd_cfg         = 32'hA5A5_A5A5;
    wait_cfg       = 1000;
    @(negedge PCLK);
    bus.i_transfer = 1'b0;
    @(negedge PCLK);
    check("access_before_rst", bus.PENABLE, 1);
`ifndef APB_TIMEOUT_EN
    nd = 0;
    repeat (40) begin
      @(negedge PCLK);
      if (bus.o_done) nd++;
    end
    check("hang_no_done", nd, 0);
    check("hang_in_access", bus.PENABLE, 1);
`endif
    PRESET = 1'b1;
    #1;
    check("arst_psel",    bus.PSEL, 0);
    check("arst_penable", bus.PENABLE, 0);
    check("arst_ready",   bus.o_ready, 1);
    check("arst_done",    bus.o_done, 0);
    check("arst_paddr",   bus.PADDR, 0);
    check("arst_rdata",   bus.o_rdata, 0);
    exp_rdata = '0;
    @(negedge PCLK);
    PRESET   = 1'b0;
    wait_cfg = 0;
    nd = 0;
    repeat (3) begin
      @(negedge PCLK);
      if (bus.o_done) nd++;
    end
    check("arst_no_done", nd, 0);
    xfer(1'b0, 32'h0000_3010, 32'h0, 32'h0BAD_CAFE, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
